// File: rtl/txmix_pkg.sv
// txmix_pkg: shared constants and types for the TX mixer frame scheduler.
// Contents: source indices, FSM state type, delimiter word, round-robin order
// table and a helper mapping a round-robin source to its slot in that table.
package txmix_pkg;

    localparam int unsigned NSRC = 6;
    localparam int unsigned NRR  = 5;

    localparam logic [2:0] SRC_P0  = 3'd0;
    localparam logic [2:0] SRC_P1  = 3'd1;
    localparam logic [2:0] SRC_P2  = 3'd2;
    localparam logic [2:0] SRC_P3  = 3'd3;
    localparam logic [2:0] SRC_ARP = 3'd4;
    localparam logic [2:0] SRC_NIC = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [8:0] DELIM_WORD = 9'h000;

    // Slot k of the table is the k-th source in round-robin order (slot 0 = port0).
    localparam logic [NRR-1:0][2:0] RR_ORDER = {SRC_NIC, SRC_P3, SRC_P2, SRC_P1, SRC_P0};

    // Slot of a round-robin source; also selects its 4-bit field in rr_weight.
    function automatic int unsigned rr_pos(input logic [2:0] src);
        int unsigned pos;
        case (src)
            SRC_P0:  pos = 0;
            SRC_P1:  pos = 1;
            SRC_P2:  pos = 2;
            SRC_P3:  pos = 3;
            default: pos = 4;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/txmix_sched_if.sv
// txmix_sched_if: source-FIFO and mixer-queue handshake bundle of the scheduler.
// Signals:
//   src_dout  : head words of the six FWFT source FIFOs, slice i = source i
//   src_empty : per-source empty
//   src_rd_en : per-source pop from the scheduler
//   dout      : word to the mixer queue
//   wr_en     : write strobe to the mixer queue
//   full      : mixer queue programmable-full
// Modports: slave = scheduler side, master = FIFO/queue environment side.
interface txmix_sched_if
    import txmix_pkg::*;
#(
    parameter int unsigned DW = 9
) ();

    logic [NSRC*DW-1:0] src_dout;
    logic [NSRC-1:0]    src_empty;
    logic [NSRC-1:0]    src_rd_en;
    logic [DW-1:0]      dout;
    logic               wr_en;
    logic               full;

    modport slave (
        input  src_dout,
        input  src_empty,
        input  full,
        output src_rd_en,
        output dout,
        output wr_en
    );

    modport master (
        output src_dout,
        output src_empty,
        output full,
        input  src_rd_en,
        input  dout,
        input  wr_en
    );

endinterface

// File: rtl/txmix_rr_pick.sv
// txmix_rr_pick: rotating-priority search over the round-robin sources.
// Ports:
//   ptr   in  current round-robin pointer (source index)
//   req   in  per-source request (non-empty) vector
//   pick  out first requesting source strictly after ptr in round-robin order,
//             wrapping around so ptr itself is the last candidate
//   valid out some round-robin source is requesting
module txmix_rr_pick
    import txmix_pkg::*;
(
    input  logic [2:0]      ptr,
    input  logic [NSRC-1:0] req,
    output logic [2:0]      pick,
    output logic            valid
);

    always_comb begin
        int unsigned pos;
        pos   = 0;
        pick  = ptr;
        valid = 1'b0;
        // Scan from the farthest slot to the nearest so the nearest requester wins.
        for (int unsigned k = NRR; k >= 1; k--) begin
            pos = (rr_pos(ptr) + k) % NRR;
            if (req[RR_ORDER[pos]]) begin
                pick  = RR_ORDER[pos];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/txmix_sched.sv
// txmix_sched: frame-granular scheduler sharing the TX mixer queue among six
// FWFT source FIFOs (ports 0-3, ARP responder, host NIC). ARP has strict
// priority limited to ARP_MAX consecutive frames; the rest share by weighted
// round robin. Over-long frames are cut and closed with a delimiter, and the
// leftover of the cut frame is later drained from its source without writing.
// Ports:
//   sys_clk    in  clock
//   sys_rst    in  asynchronous active-high reset
//   bus        slave side of txmix_sched_if (source FIFOs and mixer queue)
//   rr_weight  in  4-bit frames-per-turn for sources 0,1,2,3,5 (LSB first), 0 acts as 1
//   err_trunc  out one-cycle pulse when a frame is truncated
module txmix_sched
    import txmix_pkg::*;
#(
    parameter int unsigned DW        = 9,
    parameter int unsigned MAX_WORDS = 1600,
    parameter int unsigned ARP_MAX   = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    txmix_sched_if.slave  bus,
    input  logic [19:0]   rr_weight,
    output logic          err_trunc
);

    localparam int unsigned    AW         = $clog2(ARP_MAX + 1);
    localparam logic [10:0]    WCNT_LIMIT = 11'(MAX_WORDS - 1);
    localparam logic [AW-1:0]  ARP_CAP    = AW'(ARP_MAX);

    state_t            state_q;
    logic [2:0]        grant_q;
    logic [2:0]        rr_ptr_q;
    logic [3:0]        credit_q;
    logic [AW-1:0]     arp_run_q;
    logic [NSRC-1:0]   discard_q;
    logic              in_frame_q;
    logic [10:0]       wcnt_q;
    logic [DW-1:0]     dout_q;
    logic              wr_en_q;
    logic              err_trunc_q;

    logic [NSRC-1:0]   req;
    logic              arp_req;
    logic              rr_hold;
    logic [2:0]        pick_src;
    logic              pick_valid;
    logic [3:0]        pick_weight;
    logic [3:0]        credit_load;

    logic [DW-1:0]     head;
    logic              g_empty;
    logic              g_discard;
    logic              trunc_hit;
    logic              pop;
    logic              end_pop;
    logic              g_is_rr;

    assign req     = ~bus.src_empty;
    assign arp_req = req[SRC_ARP];
    assign rr_hold = req[rr_ptr_q] && (credit_q != 4'd0);

    txmix_rr_pick u_rr_pick (
        .ptr   (rr_ptr_q),
        .req   (req),
        .pick  (pick_src),
        .valid (pick_valid)
    );

    assign pick_weight = rr_weight[4*rr_pos(pick_src) +: 4];
    assign credit_load = (pick_weight == 4'd0) ? 4'd1 : pick_weight;

    assign head      = bus.src_dout[int'(grant_q)*DW +: DW];
    assign g_empty   = bus.src_empty[grant_q];
    assign g_discard = discard_q[grant_q];
    assign g_is_rr   = (grant_q != SRC_ARP);
    // Limit reached with no delimiter yet: stop popping and close the frame ourselves.
    assign trunc_hit = !g_discard && (wcnt_q == WCNT_LIMIT);

    always_comb begin
        pop = 1'b0;
        if (state_q == XFER) begin
            if (g_discard) begin
                pop = !g_empty;
            end else if (!trunc_hit) begin
                pop = !g_empty && !bus.full;
            end
        end
    end

    // A data-flag-low word after the frame has started is its delimiter.
    assign end_pop = pop && !head[DW-1] && in_frame_q;

    assign bus.src_rd_en = NSRC'(pop) << grant_q;
    assign bus.dout      = dout_q;
    assign bus.wr_en     = wr_en_q;
    assign err_trunc     = err_trunc_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            grant_q     <= SRC_P0;
            rr_ptr_q    <= SRC_NIC;
            credit_q    <= 4'd0;
            arp_run_q   <= '0;
            discard_q   <= '0;
            in_frame_q  <= 1'b0;
            wcnt_q      <= 11'd0;
            dout_q      <= '0;
            wr_en_q     <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            err_trunc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_frame_q <= 1'b0;
                    wcnt_q     <= 11'd0;
                    // ARP past its cap still goes if no round-robin source wants the slot.
                    if (arp_req && ((arp_run_q < ARP_CAP) || !pick_valid)) begin
                        grant_q <= SRC_ARP;
                        state_q <= XFER;
                        if (!discard_q[SRC_ARP] && (arp_run_q < ARP_CAP)) begin
                            arp_run_q <= arp_run_q + AW'(1);
                        end
                    end else if (pick_valid) begin
                        state_q   <= XFER;
                        arp_run_q <= '0;
                        if (rr_hold) begin
                            grant_q <= rr_ptr_q;
                        end else begin
                            grant_q  <= pick_src;
                            rr_ptr_q <= pick_src;
                            credit_q <= credit_load;
                        end
                    end else begin
                        arp_run_q <= '0;
                    end
                end
                XFER: begin
                    if (pop) begin
                        wcnt_q <= wcnt_q + 11'd1;
                        if (head[DW-1]) begin
                            in_frame_q <= 1'b1;
                        end
                        if (!g_discard) begin
                            wr_en_q <= 1'b1;
                            dout_q  <= head;
                        end
                        if (end_pop) begin
                            in_frame_q <= 1'b0;
                            state_q    <= IDLE;
                            if (g_discard) begin
                                discard_q[grant_q] <= 1'b0;
                            end else if (g_is_rr && (credit_q != 4'd0)) begin
                                credit_q <= credit_q - 4'd1;
                            end
                        end
                    end else if (trunc_hit && !bus.full) begin
                        // Truncated frame counts as completed; its tail is drained later.
                        dout_q             <= DW'(DELIM_WORD);
                        wr_en_q            <= 1'b1;
                        err_trunc_q        <= 1'b1;
                        discard_q[grant_q] <= 1'b1;
                        in_frame_q         <= 1'b0;
                        state_q            <= IDLE;
                        if (g_is_rr && (credit_q != 4'd0)) begin
                            credit_q <= credit_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
